// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm sequencer slice.
package alarm_pkg;

    localparam int unsigned ALARM_STATE_W = 3;
    localparam int unsigned EVENT_CNT_W   = 4;
    localparam int unsigned EVENT_CNT_MAX = 15;

    typedef enum logic [ALARM_STATE_W-1:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_SIREN    = 3'd4
    } alarm_state_e;

    typedef struct packed {
        logic siren;
        logic armed;
        logic pending;
    } alarm_flags_t;

    // Moore decode of a state code into the indicator outputs.
    function automatic alarm_flags_t flags_of(alarm_state_e st);
        alarm_flags_t f;
        f.siren   = (st == ST_SIREN);
        f.armed   = (st == ST_ARMED) || (st == ST_ENTRY) || (st == ST_SIREN);
        f.pending = (st == ST_EXIT) || (st == ST_ENTRY);
        return f;
    endfunction

    // States whose duration is governed by the tick counter.
    function automatic logic is_timed(alarm_state_e st);
        return (st == ST_EXIT) || (st == ST_ENTRY) || (st == ST_SIREN);
    endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// User/sensor requests and status outputs of the alarm sequencer.
interface alarm_sequencer_if;
    import alarm_pkg::*;

    logic                     trigger;
    logic                     arm;
    logic                     disarm;
    logic                     siren;
    logic                     armed;
    logic                     pending;
    logic [ALARM_STATE_W-1:0] state_o;
    logic [EVENT_CNT_W-1:0]   event_count;

    modport master (
        output trigger, arm, disarm,
        input  siren, armed, pending, state_o, event_count
    );

    modport slave (
        input  trigger, arm, disarm,
        output siren, armed, pending, state_o, event_count
    );

endinterface

// File: rtl/alarm_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV cycles.
module alarm_tick_gen #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_cnt;

    // Free-running count, restarted on reset and on every state change.
    always_ff @(posedge clk) begin
        if (rst || clr || (pre_cnt == PRE_LAST)) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign tick = (pre_cnt == PRE_LAST);

endmodule

// File: rtl/alarm_sequencer.sv
// Arm/exit/entry/siren controller with timed states and an intrusion counter.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned EXIT_TICKS  = 4,
    parameter int unsigned ENTRY_TICKS = 4,
    parameter int unsigned SIREN_TICKS = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    alarm_sequencer_if.slave   bus
);

    alarm_state_e     state_q;
    alarm_state_e     state_nxt;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic             expire_c;
    logic             trans_c;

    assign expire_c = tick && (tick_cnt == CNT_W'(1));
    assign trans_c  = (state_nxt != state_q);

    alarm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (trans_c),
        .tick (tick)
    );

    // Next state: disarm wins, then timeout, then trigger/arm.
    always_comb begin
        state_nxt = state_q;
        if (bus.disarm) begin
            state_nxt = ST_DISARMED;
        end else begin
            case (state_q)
                ST_DISARMED: if (bus.arm)     state_nxt = ST_EXIT;
                ST_EXIT:     if (expire_c)    state_nxt = ST_ARMED;
                ST_ARMED:    if (bus.trigger) state_nxt = ST_ENTRY;
                ST_ENTRY:    if (expire_c)    state_nxt = ST_SIREN;
                ST_SIREN:    if (expire_c)    state_nxt = ST_ARMED;
                default:                      state_nxt = ST_DISARMED;
            endcase
        end
    end

    // State, tick counter, intrusion counter and registered output decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_DISARMED;
            tick_cnt        <= '0;
            bus.event_count <= '0;
            bus.siren       <= 1'b0;
            bus.armed       <= 1'b0;
            bus.pending     <= 1'b0;
            bus.state_o     <= '0;
        end else begin
            state_q <= state_nxt;

            if (trans_c) begin
                case (state_nxt)
                    ST_EXIT:  tick_cnt <= CNT_W'(EXIT_TICKS);
                    ST_ENTRY: tick_cnt <= CNT_W'(ENTRY_TICKS);
                    ST_SIREN: tick_cnt <= CNT_W'(SIREN_TICKS);
                    default:  tick_cnt <= tick_cnt;
                endcase
            end else if (tick && is_timed(state_q)) begin
                tick_cnt <= tick_cnt - CNT_W'(1);
            end

            if ((state_q == ST_DISARMED) && (state_nxt == ST_EXIT)) begin
                bus.event_count <= '0;
            end else if ((state_q == ST_ARMED) && (state_nxt == ST_ENTRY) &&
                         (bus.event_count != EVENT_CNT_W'(EVENT_CNT_MAX))) begin
                bus.event_count <= bus.event_count + EVENT_CNT_W'(1);
            end

            {bus.siren, bus.armed, bus.pending} <= flags_of(state_nxt);
            bus.state_o <= state_nxt;
        end
    end

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Timed arm/entry/siren controller that sits directly downstream of the combinational sensor-alarm stage in `tt_um_umar316798`. It consumes that stage's level `alarm` signal (motion | door | window) as `trigger` and adds user arm/disarm control, an exit delay, an entry grace period and a bounded siren duration. All of its outputs drive `uo_out` pins through the top-level wrapper.

## Interface
Parameters:
- `TICK_DIV`, 1000: clock cycles per delay tick, ≥1.
- `EXIT_TICKS`, 4: exit-delay length in ticks, ≥1.
- `ENTRY_TICKS`, 4: entry grace length in ticks, ≥1.
- `SIREN_TICKS`, 16: siren duration in ticks, ≥1.
- `CNT_W`, 8: tick-counter width; must hold max(EXIT_TICKS, ENTRY_TICKS, SIREN_TICKS).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `trigger` in 1: level alarm from the sensor stage, sampled every cycle.
- `arm` in 1: arm request, level or pulse.
- `disarm` in 1: disarm request, highest priority.
- `siren` out 1: siren drive.
- `armed` out 1: system armed (ARMED, ENTRY or SIREN).
- `pending` out 1: exit or entry delay running.
- `state_o` out 3: state code.
- `event_count` out 4: saturating intrusion count.

## Operation
- States and codes: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, SIREN=4. Codes 5–7 are unreachable and go to DISARMED.
- Reset, evaluated at the edge: state DISARMED, tick counter 0, prescaler 0, `event_count` 0. All outputs read 0 in the cycle after the reset edge. Reset in the middle of any state behaves identically.
- Priority within a state: `disarm` first, then timeout, then `trigger`/`arm`.
- `disarm`=1 in any state: next state is DISARMED.
- DISARMED: `arm`=1 and `disarm`=0 moves to EXIT and clears `event_count` to 0. `trigger` is ignored.
- EXIT: `trigger` is ignored. After EXIT_TICKS ticks, go to ARMED.
- ARMED: `trigger`=1 moves to ENTRY and increments `event_count`, saturating at 15.
- ENTRY: after ENTRY_TICKS ticks, go to SIREN. The `trigger` level is ignored.
- SIREN: after SIREN_TICKS ticks, go to ARMED. If `trigger` is still high then, the next cycle goes to ENTRY and counts a new event.
- `arm` outside DISARMED is ignored.
- Outputs are a Moore decode of the state register:
  - `siren` = (state==SIREN).
  - `armed` = state ∈ {ARMED, ENTRY, SIREN}.
  - `pending` = state ∈ {EXIT, ENTRY}.
  - `state_o` = state code.
- Tick counter:
  - Loaded with N (the timed state's tick count) on entry to EXIT, ENTRY or SIREN.
  - On each tick: if the counter is 1, the state transitions; otherwise the counter decrements.
  - The counter is held in untimed states.

## Timing
- Prescaler: counts 0..TICK_DIV-1 and pulses `tick` for one cycle when it reaches TICK_DIV-1. It is cleared to 0 on every state transition and on reset.
- Resulting delay: every timed state lasts exactly N·TICK_DIV cycles. With TICK_DIV=1, `tick` is constantly 1.
- Request latency: a request sampled at edge k changes state, and therefore the outputs, after edge k. The observed latency is 1 cycle.
- `event_count` updates on the same edge as the ARMED→ENTRY transition.
- No input synchronisers in this block. The wrapper already feeds synchronous signals.

## Structure
- `alarm_pkg`: state enum with the fixed codes above, `ALARM_STATE_W`=3, `EVENT_CNT_MAX`=15.
- Sub-module `alarm_tick_gen`:
  - Parameter `TICK_DIV`.
  - Ports `clk`, `rst`, `clr`, `tick`.
  - Prescaler width is $clog2(TICK_DIV), minimum 1.
- The FSM, tick counter and event counter live in `alarm_sequencer`.

## Test plan
Configuration for all scenarios: TICK_DIV=2, EXIT=2, ENTRY=3, SIREN=4.
- Reset: hold `rst`=1 for 2 cycles with all inputs at 1 → all outputs 0 and `state_o`=0 from the cycle after the first reset edge.
- Arm: pulse `arm` at cycle 0 → `state_o`=1 and `pending`=1 for cycles 1–4, then `state_o`=2 and `armed`=1 at cycle 5. A `trigger` pulse at cycle 2 has no effect.
- Intrusion: `trigger`=1 at cycle 10 →
  - ENTRY for cycles 11–16 with `event_count`=1.
  - SIREN for cycles 17–24 with `siren`=1.
  - ARMED at cycle 25.
- Abort: `disarm` pulse at cycle 13 (ENTRY) → DISARMED at cycle 14. `siren` never asserts.
- Conflicting requests:
  - `arm` and `disarm` both 1 in DISARMED → remains DISARMED.
  - `trigger` held high through the end of SIREN → ARMED for 1 cycle, then ENTRY, with `event_count` incrementing.
- Saturation and reset mid-operation: 17 intrusion cycles → `event_count` stops at 15. `rst` asserted in SIREN → all outputs 0 one cycle later.
